// File: rtl/decode_nw.sv
// Decode stage: WIDTH-lane static decode, registered output bundle and branch-queue credit/tail tracking.
// Optional early redirect of mispredicted direct branches is enabled by defining DECODE_EARLY_REDIRECT_EN.
package decode_nw_pkg;
    typedef logic [31:0] pc_t;
    localparam int BQID_W = 8;

    typedef struct packed {
        logic taken;
        pc_t  pcnext;
    } bp_t;

    typedef struct packed {
        pc_t         pc;
        logic [31:0] data;
        bp_t         bp;
    } fetch_data_t;

    typedef enum logic [1:0] {FU_NONE, FU_ALU, FU_CTRL, FU_LSU} fu_t;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE,
        OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_LOAD, OP_STORE
    } op_t;

    typedef struct packed {
        logic        valid;
        fu_t         fu;
        op_t         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } si_t;

    typedef struct packed {
        pc_t              pc;
        si_t              si;
        bp_t              bp;
        logic [BQID_W-1:0] bqid;
    } di_t;
endpackage

module static_decoder
    import decode_nw_pkg::*;
(
    input  logic [31:0] i_instr,
    output si_t         o_si
);
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opc   = i_instr[6:0];
    assign w_f3    = i_instr[14:12];
    assign w_f7    = i_instr[31:25];
    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        o_si     = '0;
        o_si.rd  = i_instr[11:7];
        o_si.rs1 = i_instr[19:15];
        o_si.rs2 = i_instr[24:20];
        case (w_opc)
            7'b0110011: begin
                o_si.valid = 1'b1;
                o_si.fu    = FU_ALU;
                case ({w_f7, w_f3})
                    10'b0000000_000: o_si.op = OP_ADD;
                    10'b0100000_000: o_si.op = OP_SUB;
                    10'b0000000_001: o_si.op = OP_SLL;
                    10'b0000000_010: o_si.op = OP_SLT;
                    10'b0000000_011: o_si.op = OP_SLTU;
                    10'b0000000_100: o_si.op = OP_XOR;
                    10'b0000000_101: o_si.op = OP_SRL;
                    10'b0100000_101: o_si.op = OP_SRA;
                    10'b0000000_110: o_si.op = OP_OR;
                    10'b0000000_111: o_si.op = OP_AND;
                    default:         o_si.valid = 1'b0;
                endcase
            end
            7'b0010011: begin
                o_si.valid = 1'b1;
                o_si.fu    = FU_ALU;
                o_si.rs2   = '0;
                o_si.imm   = w_imm_i;
                case (w_f3)
                    3'b000: o_si.op = OP_ADD;
                    3'b010: o_si.op = OP_SLT;
                    3'b011: o_si.op = OP_SLTU;
                    3'b100: o_si.op = OP_XOR;
                    3'b110: o_si.op = OP_OR;
                    3'b111: o_si.op = OP_AND;
                    3'b001: begin
                        o_si.op    = OP_SLL;
                        o_si.valid = (w_f7 == 7'b0000000);
                    end
                    default: begin
                        o_si.op    = (w_f7[5]) ? OP_SRA : OP_SRL;
                        o_si.valid = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    end
                endcase
            end
            7'b0110111: begin
                o_si.valid = 1'b1;
                o_si.fu    = FU_ALU;
                o_si.op    = OP_LUI;
                o_si.imm   = w_imm_u;
            end
            7'b0010111: begin
                o_si.valid = 1'b1;
                o_si.fu    = FU_ALU;
                o_si.op    = OP_AUIPC;
                o_si.imm   = w_imm_u;
            end
            7'b1101111: begin
                o_si.valid = 1'b1;
                o_si.fu    = FU_CTRL;
                o_si.op    = OP_JAL;
                o_si.imm   = w_imm_j;
            end
            7'b1100111: begin
                o_si.valid = (w_f3 == 3'b000);
                o_si.fu    = FU_CTRL;
                o_si.op    = OP_JALR;
                o_si.imm   = w_imm_i;
            end
            7'b1100011: begin
                o_si.valid = 1'b1;
                o_si.fu    = FU_CTRL;
                o_si.rd    = '0;
                o_si.imm   = w_imm_b;
                case (w_f3)
                    3'b000:  o_si.op = OP_BEQ;
                    3'b001:  o_si.op = OP_BNE;
                    3'b100:  o_si.op = OP_BLT;
                    3'b101:  o_si.op = OP_BGE;
                    3'b110:  o_si.op = OP_BLTU;
                    3'b111:  o_si.op = OP_BGEU;
                    default: o_si.valid = 1'b0;
                endcase
            end
            7'b0000011: begin
                o_si.valid = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
                o_si.fu    = FU_LSU;
                o_si.op    = OP_LOAD;
                o_si.imm   = w_imm_i;
            end
            7'b0100011: begin
                o_si.valid = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
                o_si.fu    = FU_LSU;
                o_si.op    = OP_STORE;
                o_si.rd    = '0;
                o_si.imm   = w_imm_s;
            end
            7'b0001111: begin
                o_si.valid = 1'b1;
                o_si.fu    = FU_ALU;
                o_si.op    = OP_NOP;
            end
            default: o_si.valid = 1'b0;
        endcase
    end
endmodule

// State | meaning
// RUN   | decode and accept bundles normally
// DROP  | discard fetch until lane-0 pc matches the latched redirect target
module decode_nw
    import decode_nw_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int BQ_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            flush_i,
    input  fetch_data_t [WIDTH-1:0]         in_i,
    input  logic [WIDTH-1:0]                in_i_valid,
    output logic                            in_i_ready,
    output di_t [WIDTH-1:0]                 di_o,
    output logic [WIDTH-1:0]                di_o_valid,
    input  logic                            di_o_ready,
    output logic [WIDTH-1:0]                bq_push_valid_o,
    output pc_t [WIDTH-1:0]                 bq_push_pc_o,
    output bp_t [WIDTH-1:0]                 bq_push_bp_o,
    input  logic [$clog2(BQ_DEPTH+1)-1:0]   bq_release_i,
    output logic                            redirect_valid_o,
    output pc_t                             redirect_pc_o
);
    localparam int CW = $clog2(BQ_DEPTH + 1);
    localparam int TW = $clog2(BQ_DEPTH);
    localparam int SW = CW + 2;

    typedef enum logic {RUN, DROP} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_credits;
    logic [TW-1:0]          r_tail;
    di_t [WIDTH-1:0]        r_di;
    logic [WIDTH-1:0]       r_out_valid;
    logic                   r_redir_valid;
    pc_t                    r_redir_pc;

    si_t [WIDTH-1:0]        w_si;
    logic [WIDTH-1:0]       w_branch;
    logic [WIDTH-1:0]       w_keep;
    logic [WIDTH-1:0]       w_push;
    logic [WIDTH-1:0][TW-1:0] w_bqid;
    logic [CW-1:0]          w_need;
    logic [CW-1:0]          w_credit_next;
    logic [SW-1:0]          w_credit_sum;
    logic                   w_any_flag;
    pc_t                    w_flag_target;
    logic                   w_out_free;
    logic                   w_match;
    logic                   w_accept;
    logic                   w_discard;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        static_decoder u_dec (
            .i_instr (in_i[gi].data),
            .o_si    (w_si[gi])
        );
        assign w_branch[gi]     = (w_si[gi].fu == FU_CTRL);
        assign bq_push_pc_o[gi] = in_i[gi].pc;
        assign bq_push_bp_o[gi] = in_i[gi].bp;
    end

`ifdef DECODE_EARLY_REDIRECT_EN
    logic [WIDTH-1:0] w_flag;
    pc_t [WIDTH-1:0]  w_target;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_flag
        assign w_target[gi] = in_i[gi].pc + w_si[gi].imm;
        assign w_flag[gi]   = in_i_valid[gi]
                            && (w_si[gi].op inside {OP_BLT, OP_BLTU, OP_BGE, OP_BGEU, OP_BEQ, OP_BNE, OP_JAL})
                            && in_i[gi].bp.taken
                            && (in_i[gi].bp.pcnext != w_target[gi]);
    end

    // Lanes after the first mispredicted direct branch are on the wrong path.
    always_comb begin
        w_keep        = '0;
        w_any_flag    = 1'b0;
        w_flag_target = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!w_any_flag) begin
                w_keep[i] = in_i_valid[i];
                if (w_flag[i]) begin
                    w_any_flag    = 1'b1;
                    w_flag_target = w_target[i];
                end
            end
        end
    end
`else
    assign w_keep        = in_i_valid;
    assign w_any_flag    = 1'b0;
    assign w_flag_target = '0;
`endif

    always_comb begin
        w_need = '0;
        w_bqid = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bqid[i] = r_tail + TW'(w_need);
            if (w_keep[i] && w_branch[i]) begin
                w_need = w_need + 1'b1;
            end
        end
    end

    assign w_out_free = (r_out_valid == '0) || di_o_ready;
    assign w_match    = in_i_valid[0] && (in_i[0].pc == r_redir_pc);
    assign w_accept   = !flush_i && in_i_valid[0] && ((r_state == RUN) || w_match)
                        && w_out_free && (r_credits >= w_need);
    assign w_discard  = !flush_i && (r_state == DROP) && !w_match;
    assign w_push     = {WIDTH{w_accept}} & w_keep & w_branch;

    always_comb begin
        w_credit_sum = SW'(r_credits) + SW'(bq_release_i);
        if (w_accept) begin
            w_credit_sum = w_credit_sum - SW'(w_need);
        end
        w_credit_next = (w_credit_sum > SW'(BQ_DEPTH)) ? CW'(BQ_DEPTH) : w_credit_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= RUN;
            r_credits     <= CW'(BQ_DEPTH);
            r_tail        <= '0;
            r_di          <= '0;
            r_out_valid   <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
        end else if (flush_i) begin
            r_state       <= RUN;
            r_credits     <= CW'(BQ_DEPTH);
            r_tail        <= '0;
            r_out_valid   <= '0;
            r_redir_valid <= 1'b0;
        end else begin
            r_credits     <= w_credit_next;
            r_redir_valid <= w_accept && w_any_flag;
            if (w_accept) begin
                r_tail      <= r_tail + TW'(w_need);
                r_out_valid <= w_keep;
                for (int i = 0; i < WIDTH; i++) begin
                    r_di[i].pc   <= in_i[i].pc;
                    r_di[i].si   <= w_si[i];
                    r_di[i].bp   <= in_i[i].bp;
                    r_di[i].bqid <= BQID_W'(w_bqid[i]);
                end
                if (w_any_flag) begin
                    r_state    <= DROP;
                    r_redir_pc <= w_flag_target;
                end else begin
                    r_state    <= RUN;
                end
            end else if (di_o_ready) begin
                r_out_valid <= '0;
            end
        end
    end

    // Combinational handshakes are forced low while reset is asserted.
    assign in_i_ready       = rstn && (w_accept || w_discard);
    assign bq_push_valid_o  = {WIDTH{rstn}} & w_push;
    assign di_o             = r_di;
    assign di_o_valid       = r_out_valid;
    assign redirect_valid_o = r_redir_valid;
    assign redirect_pc_o    = r_redir_valid ? r_redir_pc : '0;

    a_contig_valid: assert property (@(posedge clk) disable iff (!rstn)
        ((in_i_valid & (in_i_valid + 1'b1)) == '0));

    a_credit_range: assert property (@(posedge clk) disable iff (!rstn)
        !flush_i |-> (w_credit_sum <= SW'(BQ_DEPTH)));

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chk
        a_out_si_valid: assert property (@(posedge clk) disable iff (!rstn)
            r_out_valid[gi] |-> r_di[gi].si.valid);
    end
endmodule

// File: tb/tb_decode_nw.sv
// Scoreboard bench for decode_nw: stimulus queues expected bundles/pushes, a negedge monitor pops and compares.
module tb_decode_nw;
    import decode_nw_pkg::*;

    localparam logic [31:0] I_ADD = 32'h003100B3;  // add x1,x2,x3
    localparam logic [31:0] I_BEQ = 32'h00000463;  // beq x0,x0,+8
    localparam logic [31:0] I_JAL = 32'h0400006F;  // jal x0,+0x40

    logic              clk = 1'b0;
    logic              rstn;
    logic              flush_i;
    fetch_data_t [1:0] in_i;
    logic [1:0]        in_i_valid;
    logic              in_i_ready;
    di_t [1:0]         di_o;
    logic [1:0]        di_o_valid;
    logic              di_o_ready;
    logic [1:0]        bq_push_valid_o;
    pc_t [1:0]         bq_push_pc_o;
    bp_t [1:0]         bq_push_bp_o;
    logic [3:0]        bq_release_i;
    logic              redirect_valid_o;
    pc_t               redirect_pc_o;

    always #5 clk = ~clk;

    decode_nw #(.WIDTH(2), .BQ_DEPTH(8)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .flush_i          (flush_i),
        .in_i             (in_i),
        .in_i_valid       (in_i_valid),
        .in_i_ready       (in_i_ready),
        .di_o             (di_o),
        .di_o_valid       (di_o_valid),
        .di_o_ready       (di_o_ready),
        .bq_push_valid_o  (bq_push_valid_o),
        .bq_push_pc_o     (bq_push_pc_o),
        .bq_push_bp_o     (bq_push_bp_o),
        .bq_release_i     (bq_release_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    typedef struct {
        logic [1:0]  mask;
        logic [1:0]  br;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [7:0]  bq0;
        logic [7:0]  bq1;
    } exp_out_t;

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } exp_push_t;

    exp_out_t  q_out[$];
    exp_push_t q_push[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic fetch_data_t mk(input logic [31:0] pc, input logic [31:0] ins,
                                       input logic tk, input logic [31:0] nx);
        fetch_data_t f;
        f.pc        = pc;
        f.data      = ins;
        f.bp.taken  = tk;
        f.bp.pcnext = nx;
        return f;
    endfunction

    task automatic exp_out(input logic [1:0] mask, input logic [1:0] br, input logic [31:0] pc0,
                           input logic [31:0] pc1, input logic [7:0] bq0, input logic [7:0] bq1);
        exp_out_t e;
        e.mask = mask; e.br = br; e.pc0 = pc0; e.pc1 = pc1; e.bq0 = bq0; e.bq1 = bq1;
        q_out.push_back(e);
    endtask

    task automatic exp_push(input logic [1:0] mask, input logic [31:0] pc0, input logic [31:0] pc1);
        exp_push_t p;
        p.mask = mask; p.pc0 = pc0; p.pc1 = pc1;
        q_push.push_back(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input fetch_data_t l0, input fetch_data_t l1, input logic [1:0] v);
        int   n   = 0;
        logic got = 1'b0;
        in_i[0]    = l0;
        in_i[1]    = l1;
        in_i_valid = v;
        while (!got && n < 20) begin
            @(negedge clk);
            got = in_i_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", got, 1'b1);
        in_i_valid = 2'b00;
    endtask

    always @(negedge clk) begin : monitor
        exp_out_t  e;
        exp_push_t p;
        if (rstn && di_o_ready && di_o_valid != 2'b00) begin
            if (q_out.size() == 0) begin
                chk("unexpected_out", di_o_valid, 2'b00);
            end else begin
                e = q_out.pop_front();
                chk("out_mask", di_o_valid, e.mask);
                chk("out_pc0", di_o[0].pc, e.pc0);
                if (e.mask[1]) chk("out_pc1", di_o[1].pc, e.pc1);
                if (e.br[0])   chk("out_bqid0", di_o[0].bqid, e.bq0);
                if (e.br[1])   chk("out_bqid1", di_o[1].bqid, e.bq1);
            end
        end
        if (rstn && bq_push_valid_o != 2'b00) begin
            if (q_push.size() == 0) begin
                chk("unexpected_push", bq_push_valid_o, 2'b00);
            end else begin
                p = q_push.pop_front();
                chk("push_mask", bq_push_valid_o, p.mask);
                if (p.mask[0]) chk("push_pc0", bq_push_pc_o[0], p.pc0);
                if (p.mask[1]) chk("push_pc1", bq_push_pc_o[1], p.pc1);
            end
        end
    end

    initial begin
        rstn         = 1'b0;
        flush_i      = 1'b0;
        in_i         = '0;
        in_i_valid   = 2'b00;
        di_o_ready   = 1'b1;
        bq_release_i = '0;

        // reset state, with a branch presented that must not push
        in_i[0]    = mk(32'h80, I_BEQ, 1'b0, 32'h0);
        in_i_valid = 2'b01;
        repeat (2) tick();
        chk("rst_di_valid", di_o_valid, 2'b00);
        chk("rst_push", bq_push_valid_o, 2'b00);
        chk("rst_ready", in_i_ready, 1'b0);
        chk("rst_redir_valid", redirect_valid_o, 1'b0);
        chk("rst_redir_pc", redirect_pc_o, 32'h0);
        chk("rst_credits", dut.r_credits, 4'd8);
        chk("rst_tail", dut.r_tail, 3'd0);
        chk("rst_state", dut.r_state, 1'b0);
        in_i_valid = 2'b00;
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // ADD + BEQ basic bundle
        exp_out(2'b11, 2'b10, 32'h100, 32'h104, 8'd0, 8'd0);
        exp_push(2'b10, 32'h100, 32'h104);
        send(mk(32'h100, I_ADD, 1'b0, 32'h0), mk(32'h104, I_BEQ, 1'b0, 32'h0), 2'b11);
        chk("basic_di_valid", di_o_valid, 2'b11);
        chk("basic_credits", dut.r_credits, 4'd7);

        // exhaust credits, block, then wrap
        exp_out(2'b11, 2'b11, 32'h110, 32'h114, 8'd1, 8'd2);
        exp_push(2'b11, 32'h110, 32'h114);
        send(mk(32'h110, I_BEQ, 1'b0, 32'h0), mk(32'h114, I_BEQ, 1'b0, 32'h0), 2'b11);
        exp_out(2'b11, 2'b11, 32'h118, 32'h11C, 8'd3, 8'd4);
        exp_push(2'b11, 32'h118, 32'h11C);
        send(mk(32'h118, I_BEQ, 1'b0, 32'h0), mk(32'h11C, I_BEQ, 1'b0, 32'h0), 2'b11);
        exp_out(2'b11, 2'b11, 32'h120, 32'h124, 8'd5, 8'd6);
        exp_push(2'b11, 32'h120, 32'h124);
        send(mk(32'h120, I_BEQ, 1'b0, 32'h0), mk(32'h124, I_BEQ, 1'b0, 32'h0), 2'b11);
        exp_out(2'b11, 2'b01, 32'h128, 32'h12C, 8'd7, 8'd0);
        exp_push(2'b01, 32'h128, 32'h12C);
        send(mk(32'h128, I_BEQ, 1'b0, 32'h0), mk(32'h12C, I_ADD, 1'b0, 32'h0), 2'b11);
        chk("full_credits", dut.r_credits, 4'd0);

        in_i[0]    = mk(32'h130, I_BEQ, 1'b0, 32'h0);
        in_i[1]    = mk(32'h134, I_ADD, 1'b0, 32'h0);
        in_i_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nocredit_ready", in_i_ready, 1'b0);
            chk("nocredit_push", bq_push_valid_o, 2'b00);
            tick();
        end
        bq_release_i = 4'd1;
        @(negedge clk);
        chk("release_cycle_ready", in_i_ready, 1'b0);
        tick();
        bq_release_i = 4'd0;
        chk("release_credits", dut.r_credits, 4'd1);
        exp_out(2'b11, 2'b01, 32'h130, 32'h134, 8'd0, 8'd0);
        exp_push(2'b01, 32'h130, 32'h134);
        @(negedge clk);
        chk("wrap_ready", in_i_ready, 1'b1);
        tick();
        in_i_valid = 2'b00;
        chk("wrap_credits", dut.r_credits, 4'd0);
        chk("wrap_tail", dut.r_tail, 3'd1);
        repeat (2) tick();

        // stall with full output register
        bq_release_i = 4'd4;
        tick();
        bq_release_i = 4'd0;
        chk("release4_credits", dut.r_credits, 4'd4);
        di_o_ready = 1'b0;
        exp_push(2'b10, 32'h300, 32'h304);
        send(mk(32'h300, I_ADD, 1'b0, 32'h0), mk(32'h304, I_BEQ, 1'b0, 32'h0), 2'b11);
        in_i[0]    = mk(32'h308, I_BEQ, 1'b0, 32'h0);
        in_i[1]    = mk(32'h30C, I_BEQ, 1'b0, 32'h0);
        in_i_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", in_i_ready, 1'b0);
            chk("stall_push", bq_push_valid_o, 2'b00);
            chk("stall_valid", di_o_valid, 2'b11);
            chk("stall_pc0", di_o[0].pc, 32'h300);
            chk("stall_pc1", di_o[1].pc, 32'h304);
            tick();
        end

        // flush with a pending accept and a release
        flush_i      = 1'b1;
        bq_release_i = 4'd2;
        @(negedge clk);
        chk("flush_ready", in_i_ready, 1'b0);
        chk("flush_push", bq_push_valid_o, 2'b00);
        tick();
        flush_i      = 1'b0;
        bq_release_i = 4'd0;
        in_i_valid   = 2'b00;
        chk("flush_di_valid", di_o_valid, 2'b00);
        chk("flush_credits", dut.r_credits, 4'd8);
        chk("flush_tail", dut.r_tail, 3'd0);
        chk("flush_state", dut.r_state, 1'b0);
        di_o_ready = 1'b1;
        tick();

        // mispredicted JAL
`ifdef DECODE_EARLY_REDIRECT_EN
        exp_out(2'b01, 2'b01, 32'h200, 32'h204, 8'd0, 8'd0);
        exp_push(2'b01, 32'h200, 32'h204);
        send(mk(32'h200, I_JAL, 1'b1, 32'h300), mk(32'h204, I_ADD, 1'b0, 32'h0), 2'b11);
        chk("redir_valid", redirect_valid_o, 1'b1);
        chk("redir_pc", redirect_pc_o, 32'h240);
        chk("redir_state_drop", dut.r_state, 1'b1);
        tick();
        chk("redir_valid_pulse", redirect_valid_o, 1'b0);
        send(mk(32'h208, I_ADD, 1'b0, 32'h0), mk(32'h20C, I_ADD, 1'b0, 32'h0), 2'b11);
        chk("drop_state_held", dut.r_state, 1'b1);
        chk("drop_no_output", di_o_valid, 2'b00);
`else
        exp_out(2'b11, 2'b01, 32'h200, 32'h204, 8'd0, 8'd0);
        exp_push(2'b01, 32'h200, 32'h204);
        send(mk(32'h200, I_JAL, 1'b1, 32'h300), mk(32'h204, I_ADD, 1'b0, 32'h0), 2'b11);
        chk("noredir_valid", redirect_valid_o, 1'b0);
        chk("noredir_pc", redirect_pc_o, 32'h0);
        chk("noredir_state", dut.r_state, 1'b0);
        exp_out(2'b11, 2'b00, 32'h208, 32'h20C, 8'd0, 8'd0);
        send(mk(32'h208, I_ADD, 1'b0, 32'h0), mk(32'h20C, I_ADD, 1'b0, 32'h0), 2'b11);
`endif
        exp_out(2'b11, 2'b10, 32'h240, 32'h244, 8'd0, 8'd1);
        exp_push(2'b10, 32'h240, 32'h244);
        send(mk(32'h240, I_ADD, 1'b0, 32'h0), mk(32'h244, I_BEQ, 1'b0, 32'h0), 2'b11);
        chk("target_state_run", dut.r_state, 1'b0);
        chk("target_credits", dut.r_credits, 4'd6);
        repeat (2) tick();

        // asynchronous reset while a bundle is held
        di_o_ready = 1'b0;
        exp_push(2'b10, 32'h400, 32'h404);
        send(mk(32'h400, I_ADD, 1'b0, 32'h0), mk(32'h404, I_BEQ, 1'b0, 32'h0), 2'b11);
        chk("held_valid", di_o_valid, 2'b11);
        in_i[0]    = mk(32'h408, I_BEQ, 1'b0, 32'h0);
        in_i_valid = 2'b01;
        #2;
        rstn = 1'b0;
        #1;
        chk("async_di_valid", di_o_valid, 2'b00);
        chk("async_di_zero", (di_o == '0), 1'b1);
        chk("async_push", bq_push_valid_o, 2'b00);
        chk("async_ready", in_i_ready, 1'b0);
        chk("async_redir", redirect_valid_o, 1'b0);
        in_i_valid = 2'b00;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("post_rst_credits", dut.r_credits, 4'd8);
        chk("post_rst_tail", dut.r_tail, 3'd0);
        chk("post_rst_valid", di_o_valid, 2'b00);

        di_o_ready = 1'b1;
        exp_out(2'b11, 2'b10, 32'h500, 32'h504, 8'd0, 8'd0);
        exp_push(2'b10, 32'h500, 32'h504);
        send(mk(32'h500, I_ADD, 1'b0, 32'h0), mk(32'h504, I_BEQ, 1'b0, 32'h0), 2'b11);
        repeat (3) tick();

        chk("sb_out_drained", q_out.size(), 0);
        chk("sb_push_drained", q_push.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
